bin_dec_onehot_seq: RTL and testbench
=====================================

# bin_dec_onehot_seq

Sequenced binary-to-one-hot decoder: the inverse of the 8-to-3 priority encoder. It accepts 3-bit binary codes over a valid/ready handshake and buffers them in a small FIFO. It replays each code as an 8-bit one-hot word held for a fixed number of cycles. It sits downstream of encoder or control logic and drives LED/select lines.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLD, 2: cycles each one-hot word stays asserted; 1..255.
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  FIFO can accept a code this cycle.
- in_code  input  [0:2]  binary code; value = {in_code[0],in_code[1],in_code[2]}, in_code[0] is the MSB.
- out  output  [0:7]  one-hot word; code n drives out[n]=1, all other bits 0.
- out_valid  output  1  out carries a word this cycle.
- busy  output  1  FIFO not empty or FSM not in IDLE.
- count  output  [$clog2(DEPTH):0]  current FIFO occupancy.

## Operation
- Push: a code is written on a rising edge with in_valid && in_ready. in_ready = (count != DEPTH), derived from registered count only. in_code is ignored when in_valid=0 or in_ready=0.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. count tracks occupancy.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any occupancy below DEPTH. When full, in_ready=0, so no push is possible even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: out=0, out_valid=0. If count!=0, pop the head, load the out register and the hold counter=HOLD-1, then go to SHOW.
  - SHOW: out=onehot(code), out_valid=1. Decrement the hold counter each cycle. At counter==0:
    - with gap enabled, go to GAP;
    - otherwise, if count!=0, pop and reload (stay in SHOW); else go to IDLE.
  - GAP (only when compiled in): out=0, out_valid=0 for exactly one cycle. Then pop and go to SHOW if count!=0, else go to IDLE.
- out is always zero or exactly one-hot; never multi-hot.
- Reset mid-operation: all state clears immediately. Buffered codes are discarded and no partial word is completed.

## Timing
- Reset values: out=8'b0, out_valid=0, in_ready=1 (count=0), busy=0, count=0, FSM=IDLE, pointers=0.
- All outputs are registered except in_ready and busy, which are combinational from registers.
- Latency: a code accepted at edge k into an empty FIFO with the FSM in IDLE appears on out after edge k+1.
- Each word is held for exactly HOLD cycles with out_valid=1.
- Without the gap: consecutive buffered words are back-to-back with no idle cycle between them.
- With the gap: words are separated by exactly one all-zero cycle.
- Throughput: one word per HOLD cycles without the gap, or per HOLD+1 cycles with it.
- count updates on the edge of the push or pop.

## Configuration
- Macro BIN_DEC_GAP_EN:
  - Defined: the GAP state exists and one out=0, out_valid=0 cycle is inserted after every word, including the last before IDLE.
  - Undefined: the GAP state and its logic are removed, and SHOW chains directly to the next word.

## Test plan
- Reset: hold rstn=0 with in_valid=1 -> out=0, out_valid=0, count=0, in_ready=1. Release -> first push accepted on the next edge.
- Single code: push 3'b101 into an idle block with HOLD=2 -> out=8'b00000100 (out[5]=1) with out_valid=1 for exactly 2 cycles starting one cycle after acceptance. Then out=0, busy=0.
- Burst: push codes 0,7,3 on consecutive cycles -> out[0], out[7], out[3] each held HOLD cycles, in order.
  - Without BIN_DEC_GAP_EN: no zero cycles between words.
  - With BIN_DEC_GAP_EN: exactly one zero cycle after each word.
- Full: DEPTH=4, push 6 codes back-to-back with in_valid held high -> in_ready deasserts when count=4. Only accepted codes are output, with no loss or duplication. in_ready reasserts the cycle after the first pop makes count=3.
- Wrap-around: push and drain 10 codes (0..7,1,2) -> pointers wrap and output order matches input order exactly.
- Reset mid-burst: with 3 codes buffered and out[6] showing, pulse rstn low -> out=0, count=0 immediately. No buffered code appears after release.

Source files
------------

// File: rtl/bin_dec_onehot_seq_if.sv
// Handshake/output bundle for bin_dec_onehot_seq: code push side plus one-hot replay side.
// master = code producer / observer, slave = the decoder.
interface bin_dec_onehot_seq_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [0:2]       in_code;
    logic [0:7]       out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  out,
        input  out_valid,
        input  busy,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output out,
        output out_valid,
        output busy,
        output count
    );
endinterface

// File: rtl/bin_dec_onehot_seq.sv
// Sequenced binary-to-one-hot decoder: FIFO-buffered 3-bit codes replayed as one-hot words held HOLD cycles.
// Define BIN_DEC_GAP_EN to insert one all-zero cycle after every word.
module bin_dec_onehot_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input logic                clk,
    input logic                rstn,
    bin_dec_onehot_seq_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1
`ifdef BIN_DEC_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [0:OUT_W-1]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                ready_c;
    logic                push_c;
    logic                pop_c;
    logic [CODE_W-1:0]   head_c;

    // One-hot with code n driving bit index n of the [0:7] output.
    function automatic logic [0:OUT_W-1] onehot(input logic [CODE_W-1:0] code);
        logic [0:OUT_W-1] w;
        w = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w[i] = (code == CODE_W'(i));
        end
        return w;
    endfunction

    assign ready_c = (count_q != CNT_FULL);
    assign push_c  = bus.in_valid && ready_c;
    assign head_c  = mem_q[rd_ptr_q];

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state and output logic; pop_c doubles as the "load next word" strobe.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pop_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c = 1'b1;
                end
            end
            SHOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
`ifdef BIN_DEC_GAP_EN
                    state_d     = GAP;
                    out_d       = '0;
                    out_valid_d = 1'b0;
`else
                    if (count_q != '0) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                    end
`endif
                end
            end
`ifdef BIN_DEC_GAP_EN
            GAP: begin
                if (count_q != '0) begin
                    pop_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase

        if (pop_c) begin
            state_d     = SHOW;
            out_d       = onehot(head_c);
            out_valid_d = 1'b1;
            hold_d      = HOLD_LOAD;
        end
    end

    // FIFO storage and pointers; pointer width makes the wrap modulo DEPTH implicit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= bus.in_code;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.busy      = (count_q != '0) || (state_q != IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_bin_dec_onehot_seq.sv
// Self-checking bench for bin_dec_onehot_seq against a queue-based reference of the replay rules.
// Build with BIN_DEC_GAP_EN defined to exercise the gap variant.
module tb_bin_dec_onehot_seq;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 2;
`ifdef BIN_DEC_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bin_dec_onehot_seq_if #(.DEPTH(DEPTH)) bus ();

    bin_dec_onehot_seq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: pending codes, word on display (-1 = none), cycles left for it, gap flag.
    int q[$];
    int show_code = -1;
    int show_left = 0;
    bit in_gap    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        show_code = -1;
        show_left = 0;
        in_gap    = 1'b0;
    endtask

    // Advance the reference across one rising edge given the inputs presented before it.
    task automatic model_edge(input bit v, input int code);
        bit acc;
        acc = v && (q.size() < DEPTH);
        if (show_code >= 0 && show_left > 1) begin
            show_left--;
        end else if (show_code >= 0 && GAP_EN) begin
            show_code = -1;
            in_gap    = 1'b1;
        end else begin
            in_gap = 1'b0;
            if (q.size() > 0) begin
                show_code = q.pop_front();
                show_left = HOLD;
            end else begin
                show_code = -1;
            end
        end
        if (acc) q.push_back(code);
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_out;
        exp_out = (show_code >= 0) ? (8'h80 >> show_code) : 8'h00;
        chk({tag, ".out"},       32'(bus.out),       32'(exp_out));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(show_code >= 0));
        chk({tag, ".count"},     32'(bus.count),     32'(q.size()));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(q.size() != DEPTH));
        chk({tag, ".busy"},      32'(bus.busy),      32'((q.size() != 0) || (show_code >= 0) || in_gap));
        chk({tag, ".onehot0"},   32'($onehot0(bus.out)), 32'(1));
    endtask

    task automatic cycle(input bit v, input int code, input string tag);
        bus.in_valid = v;
        bus.in_code  = 3'(code);
        @(posedge clk);
        model_edge(v, code);
        #1;
        check_all(tag);
    endtask

    // Offer a code with in_valid held high until the reference accepts it (bounded).
    task automatic push_wait(input int code, input string tag);
        bit acc;
        for (int i = 0; i < 40; i++) begin
            acc = (q.size() < DEPTH);
            cycle(1'b1, code, tag);
            if (acc) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL %s.timeout observed=not_accepted expected=accepted", tag);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, tag);
    endtask

    initial begin
        int wrap_codes[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2};

        // Reset held with in_valid asserted.
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd7;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out",       32'(bus.out),       32'(0));
        chk("rst.out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst.count",     32'(bus.count),     32'(0));
        chk("rst.in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst.busy",      32'(bus.busy),      32'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Single code 5: accepted on the first edge, shown for HOLD cycles one edge later.
        cycle(1'b1, 5, "single");
        chk("single.acc_count", 32'(bus.count), 32'(1));
        chk("single.acc_out",   32'(bus.out),   32'(0));
        cycle(1'b0, 0, "single");
        chk("single.w1_out",   32'(bus.out),       32'(8'b00000100));
        chk("single.w1_valid", 32'(bus.out_valid), 32'(1));
        cycle(1'b0, 0, "single");
        chk("single.w2_out",   32'(bus.out),       32'(8'b00000100));
        cycle(1'b0, 0, "single");
        chk("single.end_out",   32'(bus.out),       32'(0));
        chk("single.end_valid", 32'(bus.out_valid), 32'(0));
        drain(2, "single_drain");
        chk("single.idle_busy", 32'(bus.busy), 32'(0));

        // Burst 0,7,3 on consecutive cycles.
        cycle(1'b1, 0, "burst");
        cycle(1'b1, 7, "burst");
        cycle(1'b1, 3, "burst");
        drain(12, "burst_drain");

        // Fill past DEPTH with in_valid held high.
        for (int i = 0; i < 6; i++) push_wait(i + 1, "full");
        drain(20, "full_drain");

        // Ten codes through the FIFO so both pointers wrap.
        for (int i = 0; i < 10; i++) push_wait(wrap_codes[i], "wrap");
        drain(30, "wrap_drain");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)), "rand");
        end
        drain(40, "rand_drain");
        chk("rand.idle_busy", 32'(bus.busy), 32'(0));

        // Reset while out[6] is showing with three codes buffered.
        push_wait(5, "mid");
        push_wait(6, "mid");
        push_wait(1, "mid");
        push_wait(2, "mid");
        push_wait(4, "mid");
        chk("mid.pre_out",   32'(bus.out),   32'(8'h02));
        chk("mid.pre_count", 32'(bus.count), 32'(3));
        bus.in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_clear();
        chk("mid.rst_out",       32'(bus.out),       32'(0));
        chk("mid.rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("mid.rst_count",     32'(bus.count),     32'(0));
        chk("mid.rst_busy",      32'(bus.busy),      32'(0));
        @(negedge clk);
        rstn = 1'b1;
        drain(10, "post_rst");
        chk("post_rst.out", 32'(bus.out), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
